// File: rtl/psx_ddr_pkg.sv
// Shared definitions for the GPU-side DDR responder: burst lengths, tracker
// states and the command-size codes used by the matching initiator.
package psx_ddr_pkg;

    localparam logic [2:0] BURST_1 = 3'd1;
    localparam logic [2:0] BURST_4 = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } resp_state_t;

    typedef enum logic [1:0] {
        SIZE_8B  = 2'd0,
        SIZE_32B = 2'd1,
        SIZE_4B  = 2'd2
    } cmd_size_t;

    // Beats of a 4-beat burst stay inside one 32-byte block, so only the low
    // two word-address bits advance and they wrap.
    function automatic logic [1:0] beatOffset(input logic [1:0] baseLow,
                                              input logic [1:0] beat);
        return baseLow + beat;
    endfunction

endpackage

// File: rtl/ddr_beat_ram.sv
// 64-bit wide word store with per-byte write enables and a registered read
// port; no reset so that synthesis can map it onto block RAM.
module ddr_beat_ram
    import psx_ddr_pkg::*;
#(
    parameter int    ADDR_W    = 17,
    parameter string INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [63:0]       wdata_i,
    input  logic [7:0]        wbe_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [63:0]       rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/psx_ddr_responder.sv
// Memory-backed Avalon-MM responder for the GPU DDR initiator: fixed read
// latency, rotating waitrequest pattern and a burst protocol checker.
module psx_ddr_responder
    import psx_ddr_pkg::*;
#(
    parameter int          ADDR_W        = 17,
    parameter int          READ_LATENCY  = 2,
    parameter logic [15:0] STALL_PATTERN = 16'h0000,
    parameter string       INIT_FILE     = ""
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_targetAddr,
    input  logic [2:0]        i_burstLength,
    output logic              o_busyMem,
    input  logic              i_writeEnableMem,
    input  logic              i_readEnableMem,
    input  logic [63:0]       i_dataMem,
    input  logic [7:0]        i_byteEnableMem,
    output logic              o_dataValidMem,
    output logic [63:0]       o_dataMem,
    output logic              o_protoErr
);

    logic [15:0] stall_q;
    logic        accepted;
    logic        bothCmd;
    logic        rdAccept;
    logic        wrAccept;
    logic [63:0] ramRdata;

    // Waitrequest comes straight from a rotating register, never from inputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_q <= STALL_PATTERN;
        end else begin
            stall_q <= {stall_q[0], stall_q[15:1]};
        end
    end

    assign o_busyMem = stall_q[0];

    assign accepted = (i_readEnableMem | i_writeEnableMem) & ~stall_q[0];
    assign bothCmd  = i_readEnableMem & i_writeEnableMem;
    assign rdAccept = accepted & i_readEnableMem & ~i_writeEnableMem;
    assign wrAccept = accepted & i_writeEnableMem & ~i_readEnableMem;

    ddr_beat_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (i_clk),
        .we_i    (wrAccept),
        .waddr_i (i_targetAddr),
        .wdata_i (i_dataMem),
        .wbe_i   (i_byteEnableMem),
        .re_i    (rdAccept),
        .raddr_i (i_targetAddr),
        .rdata_o (ramRdata)
    );

    // ------------------------------------------------------------------
    // Read return path: the RAM supplies the first cycle of latency.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] vld_d;
    logic [63:0]             pipeData;
    logic [63:0]             hold_q;
    logic                    retValid;

    assign vld_d = (vld_q << 1) | READ_LATENCY'(rdAccept);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    if (READ_LATENCY == 1) begin : g_noStage
        assign pipeData = ramRdata;
    end else begin : g_stages
        logic [63:0] stage_q [READ_LATENCY-1];

        always_ff @(posedge i_clk) begin
            stage_q[0] <= ramRdata;
            for (int k = 1; k < READ_LATENCY - 1; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end

        assign pipeData = stage_q[READ_LATENCY-2];
    end

    assign retValid = vld_q[READ_LATENCY-1];

    // The output bus keeps showing the last returned word between valids.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_q <= '0;
        end else if (retValid) begin
            hold_q <= pipeData;
        end
    end

    assign o_dataValidMem = retValid;
    assign o_dataMem      = retValid ? pipeData : hold_q;

    // ------------------------------------------------------------------
    // Transaction tracker
    // ------------------------------------------------------------------
    resp_state_t       state_q;
    logic [ADDR_W-1:0] base_q;
    logic [2:0]        len_q;
    logic [1:0]        beat_q;
    logic              protoErr_q;
    logic [ADDR_W-1:0] expAddr;
    logic              typeMatch;
    logic              beatMatch;

    assign expAddr   = {base_q[ADDR_W-1:2], beatOffset(base_q[1:0], beat_q)};
    assign typeMatch = (state_q == RD_BURST) ? i_readEnableMem : i_writeEnableMem;
    assign beatMatch = typeMatch && (i_targetAddr == expAddr) && (i_burstLength == len_q);

    // An illegal read+write abandons any burst in progress. A beat that does
    // not continue the current burst still executes and opens a new one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= BURST_1;
            beat_q     <= '0;
            protoErr_q <= 1'b0;
        end else if (accepted) begin
            if (bothCmd) begin
                protoErr_q <= 1'b1;
                state_q    <= IDLE;
            end else if ((state_q != IDLE) && beatMatch) begin
                beat_q <= beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_q <= IDLE;
                end
            end else begin
                if (state_q != IDLE) begin
                    protoErr_q <= 1'b1;
                end
                base_q <= i_targetAddr;
                len_q  <= i_burstLength;
                beat_q <= 2'd1;
                if (i_burstLength == BURST_4) begin
                    state_q <= i_readEnableMem ? RD_BURST : WR_BURST;
                end else begin
                    state_q <= IDLE;
                    if (i_burstLength != BURST_1) begin
                        protoErr_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_protoErr = protoErr_q;

endmodule
